wb_regfile_flags: RTL

//  Writeback-end consumer of the MEM/WB pipeline register in the dual-issue core. It holds the
//  8x32 architectural register file and the NZCV flag register, and applies up to two register

---
 rtl/core_pkg.sv | 12 +
 rtl/rf_read_bypass.sv | 34 +++
 rtl/wb_regfile_flags.sv | 123 ++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared definitions for the dual-issue core: datapath widths and the NZCV flag layout.
package core_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] flags_t;
endpackage

// File: rtl/rf_read_bypass.sv
// One combinational register-file read port with write-first forwarding from the two
// writeback writes; the younger instruction (inst2) wins when both hit.
module rf_read_bypass
    import core_pkg::*;
#(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int ADDR_W = core_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic [ADDR_W-1:0]                   ra,
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]  regs,
    input  logic                                we1,
    input  logic [ADDR_W-1:0]                   wa1,
    input  logic [DATA_W-1:0]                   wd1,
    input  logic                                we2,
    input  logic [ADDR_W-1:0]                   wa2,
    input  logic [DATA_W-1:0]                   wd2,
    output logic [DATA_W-1:0]                   rd
);
    logic hit1;
    logic hit2;

    assign hit1 = we1 && (ra == wa1);
    assign hit2 = we2 && (ra == wa2);

    always_comb begin
        rd = regs[ra];
        if ((BYPASS != 0) && hit2) begin
            rd = wd2;
        end else if ((BYPASS != 0) && hit1) begin
            rd = wd1;
        end
    end
endmodule

// File: rtl/wb_regfile_flags.sv
// Writeback stage of the dual-issue core: 8-entry register file, NZCV flag register and
// four forwarding read ports. Inst2 is younger and takes precedence on collisions.
module wb_regfile_flags
    import core_pkg::*;
#(
    parameter int DATA_W = core_pkg::DATA_W,
    parameter int ADDR_W = core_pkg::ADDR_W,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              regWrite1,
    input  logic [ADDR_W-1:0] DestReg1,
    input  logic [DATA_W-1:0] WriteData1,
    input  logic              regWrite2,
    input  logic [ADDR_W-1:0] DestReg2,
    input  logic [DATA_W-1:0] WriteData2,
    input  logic              flagWrite1,
    input  logic [3:0]        inst1Flags,
    input  logic              flagWrite2,
    input  logic [3:0]        inst2Flags,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    input  logic [ADDR_W-1:0] ra3,
    input  logic [ADDR_W-1:0] ra4,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic [DATA_W-1:0] rd3,
    output logic [DATA_W-1:0] rd4,
    output logic [3:0]        NZCV,
    output logic              wrConflict
);
    localparam int NREGS = 2**ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;
    flags_t                       flags_q;
    flags_t                       flags_d;
    logic                         conflict_q;
    logic                         conflict_d;

    // Forwarding is suppressed while reset is held so readers see the cleared state.
    logic                         fwd_we1;
    logic                         fwd_we2;

    assign fwd_we1 = regWrite1 & ~reset;
    assign fwd_we2 = regWrite2 & ~reset;

    always_comb begin
        regs_d = regs_q;
        for (int i = 0; i < NREGS; i++) begin
            if (regWrite2 && (DestReg2 == ADDR_W'(i))) begin
                regs_d[i] = WriteData2;
            end else if (regWrite1 && (DestReg1 == ADDR_W'(i))) begin
                regs_d[i] = WriteData1;
            end
        end
    end

    always_comb begin
        flags_d = flags_q;
        if (flagWrite2) begin
            flags_d = inst2Flags;
        end else if (flagWrite1) begin
            flags_d = inst1Flags;
        end
    end

    assign conflict_d = regWrite1 && regWrite2 && (DestReg1 == DestReg2);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q     <= '0;
            flags_q    <= '0;
            conflict_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            flags_q    <= flags_d;
            conflict_q <= conflict_d;
        end
    end

    assign wrConflict = conflict_q;

    always_comb begin
        NZCV = flags_q;
        if (reset) begin
            NZCV = '0;
        end else if (BYPASS != 0) begin
            NZCV = flags_d;
        end
    end

    logic [3:0][ADDR_W-1:0] ra_w;
    logic [3:0][DATA_W-1:0] rd_w;

    assign ra_w = {ra4, ra3, ra2, ra1};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rd
            rf_read_bypass #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .BYPASS (BYPASS)
            ) u_rd (
                .ra   (ra_w[gi]),
                .regs (regs_q),
                .we1  (fwd_we1),
                .wa1  (DestReg1),
                .wd1  (WriteData1),
                .we2  (fwd_we2),
                .wa2  (DestReg2),
                .wd2  (WriteData2),
                .rd   (rd_w[gi])
            );
        end
    endgenerate

    assign rd1 = rd_w[0];
    assign rd2 = rd_w[1];
    assign rd3 = rd_w[2];
    assign rd4 = rd_w[3];
endmodule
